// File: rtl/ro_measure_pkg.sv
// ---------------------------------------------------------------------------
// ro_measure_pkg
//   Shared definitions for the ring-oscillator measurement block.
//   - ro_state_e : FSM state encoding (also what the state_dbg port carries)
//   - sel_width  : width of the oscillator-select field for a given N_OSC
//   - win_width  : width of the window-length field of buffer_in
// ---------------------------------------------------------------------------
package ro_measure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } ro_state_e;

  // Select field is clog2(N_OSC) bits wide, but never narrower than one bit
  // so that a single-oscillator build still has a well-formed field.
  function automatic int sel_width(input int n_osc);
    return (n_osc <= 2) ? 1 : $clog2(n_osc);
  endfunction

  // Everything above the select field is the window length.
  function automatic int win_width(input int buffer_in_width, input int n_osc);
    return buffer_in_width - sel_width(n_osc);
  endfunction

endpackage

// File: rtl/ro_measure_pl_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Two-flop synchronizer followed by a rising-edge detector on one bit.
//
// Ports
//   clock    in  1  system clock, rising edge
//   reset_n  in  1  asynchronous active-low reset, clears all flops
//   d        in  1  asynchronous input bit
//   reload   in  1  resynchronise the edge detector: the previous-value
//                   register takes the value the synchronizer output is about
//                   to take, so the next cycle cannot report an edge
//   pulse    out 1  one-cycle pulse when the synchronized bit goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  input  logic reload,
  output logic pulse
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      // On reload, prev follows s1 (the next s2), so s2 == prev on the
      // following cycle and whatever history sat in the chain is discarded.
      if (reload) begin
        prev <= s1;
      end else begin
        prev <= s2;
      end
    end
  end

  assign pulse = s2 & ~prev;

endmodule

// File: rtl/ro_measure_pl.sv
// ---------------------------------------------------------------------------
// ro_measure_pl
//   PL-side ring-oscillator measurement engine. On a PS command it selects one
//   oscillator, counts its rising edges over a programmed number of clock
//   cycles and returns the count.
//
// Handshake: sync is a level request from the PS side; buffer_in must be
//   stable while sync=1. ack is a registered level that rises once the result
//   is on buffer_out and stays high until sync is seen low, after which ack
//   drops on the next cycle. Dropping sync before ack (during LOAD/COUNT)
//   aborts the measurement without touching buffer_out.
//
// Parameters
//   N_OSC             number of oscillator inputs
//   BUFFER_IN_WIDTH   buffer_in width: [SEL_W-1:0] select, upper bits window
//   BUFFER_OUT_WIDTH  result width
//
// Ports
//   clock       in   1                 system clock, rising edge
//   reset_n     in   1                 asynchronous active-low reset
//   osc_in      in   N_OSC             ring-oscillator outputs (asynchronous)
//   sync        in   1                 command request level
//   ack         out  1                 measurement done, held until sync low
//   buffer_in   in   BUFFER_IN_WIDTH   {window, select}
//   buffer_out  out  BUFFER_OUT_WIDTH  result, valid whenever ack=1
//   state_dbg   out  2                 current FSM state (ro_state_e encoding)
//
// Build option
//   RO_MEASURE_OVF_FLAG_EN: MSB of buffer_out becomes an overflow flag and the
//   count uses the remaining bits. Undefined: count uses all bits and
//   saturates silently.
// ---------------------------------------------------------------------------
module ro_measure_pl
  import ro_measure_pkg::*;
#(
  parameter int N_OSC            = 8,
  parameter int BUFFER_IN_WIDTH  = 16,
  parameter int BUFFER_OUT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_OSC-1:0]            osc_in,
  input  logic                        sync,
  output logic                        ack,
  input  logic [BUFFER_IN_WIDTH-1:0]  buffer_in,
  output logic [BUFFER_OUT_WIDTH-1:0] buffer_out,
  output logic [1:0]                  state_dbg
);

  localparam int SEL_W = sel_width(N_OSC);
  localparam int WIN_W = win_width(BUFFER_IN_WIDTH, N_OSC);
`ifdef RO_MEASURE_OVF_FLAG_EN
  localparam int CNT_W = BUFFER_OUT_WIDTH - 1;
`else
  localparam int CNT_W = BUFFER_OUT_WIDTH;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ro_state_e state;
  ro_state_e state_nxt;

  logic [SEL_W-1:0]            sel_in;
  logic [SEL_W-1:0]            sel_q;
  logic [SEL_W-1:0]            sel_mux;
  logic [WIN_W-1:0]            win_in;
  logic [WIN_W-1:0]            win_q;
  logic [WIN_W-1:0]            win_cnt;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_nxt;
  logic [BUFFER_OUT_WIDTH-1:0] result;
  logic                        osc_bit;
  logic                        edge_pulse;
  logic                        edge_inc;
  logic                        last_cycle;
  logic                        done_entry;
  logic                        load_phase;

  assign sel_in    = buffer_in[SEL_W-1:0];
  assign win_in    = buffer_in[BUFFER_IN_WIDTH-1:SEL_W];
  assign state_dbg = state;

  // Before COUNT the mux follows buffer_in directly (stable while sync=1), so
  // the synchronizer is already fed from the new oscillator during IDLE/LOAD.
  assign sel_mux = (state == ST_COUNT) ? sel_q : sel_in;

  // Out-of-range selects match no input and leave osc_bit at 0.
  always_comb begin
    osc_bit = 1'b0;
    for (int i = 0; i < N_OSC; i++) begin
      if (sel_mux == SEL_W'(i)) begin
        osc_bit = osc_in[i];
      end
    end
  end

  assign load_phase = (state == ST_LOAD);

  sync_edge_det u_sync_edge_det (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (osc_bit),
    .reload  (load_phase),
    .pulse   (edge_pulse)
  );

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  assign last_cycle = (win_cnt == (win_q - WIN_W'(1)));
  assign edge_inc   = (state == ST_COUNT) && edge_pulse;

  always_comb begin
    cnt_nxt = cnt_q;
    if (edge_inc && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

`ifdef RO_MEASURE_OVF_FLAG_EN
  logic ovf_q;
  logic ovf_nxt;

  // Sticky for the current window: set when an edge arrives with the counter
  // already pinned at its maximum.
  assign ovf_nxt = ovf_q | (edge_inc && (cnt_q == CNT_MAX));
  assign result  = {ovf_nxt, cnt_nxt};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (state == ST_LOAD) begin
      ovf_q <= 1'b0;
    end else if (state == ST_COUNT) begin
      ovf_q <= ovf_nxt;
    end
  end
`else
  assign result = cnt_nxt;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (sync) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!sync) begin
          state_nxt = ST_IDLE;
        end else if (win_in == '0) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Abort takes priority over completing the window.
        if (!sync) begin
          state_nxt = ST_IDLE;
        end else if (last_cycle) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!sync) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign done_entry = (state_nxt == ST_DONE) && (state != ST_DONE);

  // ---------------------------------------------------------------------------
  // State, counters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ack        <= 1'b0;
      buffer_out <= '0;
      sel_q      <= '0;
      win_q      <= '0;
      win_cnt    <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_nxt;
      ack   <= (state_nxt == ST_DONE);
      case (state)
        ST_LOAD: begin
          sel_q   <= sel_in;
          win_q   <= win_in;
          win_cnt <= '0;
          cnt_q   <= '0;
        end
        ST_COUNT: begin
          win_cnt <= win_cnt + WIN_W'(1);
          cnt_q   <= cnt_nxt;
        end
        default: begin
        end
      endcase
      // Zero-length window goes straight from LOAD to DONE with count 0;
      // otherwise the result includes any edge on the final COUNT cycle.
      if (done_entry) begin
        buffer_out <= (state == ST_LOAD) ? '0 : result;
      end
    end
  end

endmodule

// File: tb/tb_ro_measure_pl.sv
// ---------------------------------------------------------------------------
// tb_ro_measure_pl
//   Directed bench for ro_measure_pl. Six oscillators are used so that select
//   values 6 and 7 are out of range; the select field is 3 bits and the
//   window field 13 bits. An 8-bit result makes saturation reachable.
// ---------------------------------------------------------------------------
module tb_ro_measure_pl;

  localparam int N_OSC = 6;
  localparam int BIW   = 16;
  localparam int BOW   = 8;

  logic             clock;
  logic             reset_n;
  logic [N_OSC-1:0] osc_in;
  logic             sync;
  logic             ack;
  logic [BIW-1:0]   buffer_in;
  logic [BOW-1:0]   buffer_out;
  logic [1:0]       state_dbg;

  int checks;
  int failures;

  // 0: oscillators static, 1: osc_in[3] at clock/4,
  // 2: all at clock/2, 3: all at clock/4
  int         osc_mode;
  logic [7:0] div;

  ro_measure_pl #(
    .N_OSC            (N_OSC),
    .BUFFER_IN_WIDTH  (BIW),
    .BUFFER_OUT_WIDTH (BOW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .osc_in     (osc_in),
    .sync       (sync),
    .ack        (ack),
    .buffer_in  (buffer_in),
    .buffer_out (buffer_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Oscillators change on the falling edge, away from the sampling edge.
  initial begin
    div    = '0;
    osc_in = '0;
    forever begin
      @(negedge clock);
      div = div + 8'd1;
      osc_in = '0;
      case (osc_mode)
        1: osc_in[3] = div[1];
        2: osc_in = {N_OSC{div[0]}};
        3: osc_in = {N_OSC{div[1]}};
        default: osc_in = '0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_cmd(input int win, input int sel);
    buffer_in = {13'(win), 3'(sel)};
    sync      = 1'b1;
  endtask

  // Returns number of rising edges from sync assertion until ack is seen,
  // or -1 if the budget expires.
  task automatic wait_ack(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (ack === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    sync      = 1'b0;
    buffer_in = '0;
    osc_mode  = 0;
    repeat (3) tick();
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b exp=0", ack);
    end
    checks++;
    if (buffer_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_buffer_out got=%h exp=00", buffer_out);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", state_dbg);
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_window_zero();
    int lat;
    start_cmd(0, 2);
    wait_ack(20, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL win0_latency got=%0d exp=2", lat);
    end
    checks++;
    if (buffer_out !== 8'h00) begin
      failures++;
      $display("FAIL win0_value got=%h exp=00", buffer_out);
    end
    sync = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL win0_ack_release got=%b exp=0", ack);
    end
    tick();
  endtask

  task automatic test_saturate();
    int lat;
    osc_mode = 2;
    start_cmd(4095, 1);
    wait_ack(4200, lat);
    checks++;
    if (lat !== 4097) begin
      failures++;
      $display("FAIL sat_latency got=%0d exp=4097", lat);
    end
    // ~2047 edges: plain build pins at 8'hFF; with the overflow flag the
    // count pins at 127 and the flag is set, also 8'hFF.
    checks++;
    if (buffer_out !== 8'hFF) begin
      failures++;
      $display("FAIL sat_value got=%h exp=ff", buffer_out);
    end
    sync = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL sat_ack_release got=%b exp=0", ack);
    end
    osc_mode = 0;
    tick();
  endtask

  task automatic test_abort();
    int lat;
    bit seen_ack;
    osc_mode = 1;
    start_cmd(200, 3);
    // edge 1 -> LOAD, edges 2..6 are COUNT cycles 1..5
    repeat (6) tick();
    sync = 1'b0;
    seen_ack = 1'b0;
    for (int n = 0; n < 250; n++) begin
      tick();
      if (ack === 1'b1) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_ack got=%b exp=0", seen_ack);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL abort_state got=%0d exp=0", state_dbg);
    end
    checks++;
    if (buffer_out !== 8'hFF) begin
      failures++;
      $display("FAIL abort_keeps_result got=%h exp=ff", buffer_out);
    end
    // Next command must be accepted normally.
    start_cmd(0, 0);
    wait_ack(20, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL abort_next_latency got=%0d exp=2", lat);
    end
    checks++;
    if (buffer_out !== 8'h00) begin
      failures++;
      $display("FAIL abort_next_value got=%h exp=00", buffer_out);
    end
    sync = 1'b0;
    osc_mode = 0;
    repeat (2) tick();
  endtask

  task automatic test_invalid_sel();
    int lat;
    osc_mode = 3;
    // select 7 is beyond the six oscillators
    start_cmd(50, 7);
    wait_ack(100, lat);
    checks++;
    if (lat !== 52) begin
      failures++;
      $display("FAIL badsel_latency got=%0d exp=52", lat);
    end
    checks++;
    if (buffer_out !== 8'h00) begin
      failures++;
      $display("FAIL badsel_value got=%h exp=00", buffer_out);
    end
    sync = 1'b0;
    osc_mode = 0;
    repeat (2) tick();
  endtask

  task automatic test_count();
    int lat;
    osc_mode = 1;
    repeat (4) tick();
    start_cmd(40, 3);
    wait_ack(100, lat);
    checks++;
    if (lat !== 42) begin
      failures++;
      $display("FAIL count_latency got=%0d exp=42", lat);
    end
    // clock/4 over 40 cycles: 10 edges, one may straddle the window start
    checks++;
    if (!(buffer_out >= 8'd9 && buffer_out <= 8'd11)) begin
      failures++;
      $display("FAIL count_value got=%0d exp=10(+/-1)", buffer_out);
    end
    sync = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL count_ack_release got=%b exp=0", ack);
    end
    tick();
  endtask

  task automatic test_reset_mid_count();
    osc_mode = 1;
    start_cmd(100, 3);
    repeat (50) tick();
    checks++;
    if (state_dbg !== 2'd2) begin
      failures++;
      $display("FAIL midrst_pre_state got=%0d exp=2", state_dbg);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ack got=%b exp=0", ack);
    end
    checks++;
    if (buffer_out !== 8'h00) begin
      failures++;
      $display("FAIL midrst_buffer_out got=%h exp=00", buffer_out);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL midrst_state got=%0d exp=0", state_dbg);
    end
    sync = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    osc_mode = 0;
    repeat (2) tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    osc_mode  = 0;
    reset_n   = 1'b0;
    sync      = 1'b0;
    buffer_in = '0;
    test_reset();
    test_window_zero();
    test_saturate();
    test_abort();
    test_invalid_sel();
    test_count();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
